// File: rtl/control_unit.sv
// Multi-cycle LEGv8 sequencer: fetch -> decode -> execute (-> mem) driving the DataPath control word.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap into a sticky HALT state instead of acting as NOP.
module control_unit #(
  parameter int FETCH_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_out,
  input  logic        zero,
  output logic        write,
  output logic [4:0]  rdAddrA,
  output logic [4:0]  rdAddrB,
  output logic [4:0]  wrAddr,
  output logic [63:0] K,
  output logic [4:0]  FS,
  output logic        C_in,
  output logic        B_sel,
  output logic        ramWrite,
  output logic        PC_sel,
  output logic [1:0]  PS,
  output logic        IR_load,
  output logic        AS,
  output logic [1:0]  DS,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] FW = 3'(FETCH_WAIT);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic        is_add, is_sub, is_and, is_orr, is_ldur, is_stur, is_addi, is_cbz, is_b;
  logic [63:0] dt_sext, br_sext, cb_sext, imm_zext;

  assign is_add  = (IR_out[31:21] == 11'b10001011000);
  assign is_sub  = (IR_out[31:21] == 11'b11001011000);
  assign is_and  = (IR_out[31:21] == 11'b10001010000);
  assign is_orr  = (IR_out[31:21] == 11'b10101010000);
  assign is_ldur = (IR_out[31:21] == 11'b11111000010);
  assign is_stur = (IR_out[31:21] == 11'b11111000000);
  assign is_addi = (IR_out[31:22] == 10'b1001000100);
  assign is_cbz  = (IR_out[31:24] == 8'b10110100);
  assign is_b    = (IR_out[31:26] == 6'b000101);

  assign dt_sext  = {{55{IR_out[20]}}, IR_out[20:12]};
  assign br_sext  = {{38{IR_out[25]}}, IR_out[25:0]};
  assign cb_sext  = {{45{IR_out[23]}}, IR_out[23:5]};
  assign imm_zext = {52'd0, IR_out[21:10]};

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RST;
      cnt_q     <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    write    = 1'b0;
    rdAddrA  = 5'd0;
    rdAddrB  = 5'd0;
    wrAddr   = 5'd0;
    K        = 64'd0;
    FS       = 5'd0;
    C_in     = 1'b0;
    B_sel    = 1'b0;
    ramWrite = 1'b0;
    PC_sel   = 1'b0;
    PS       = 2'b00;
    IR_load  = 1'b0;
    AS       = 1'b0;
    DS       = 2'b00;

    case (state_q)
      ST_RST: begin
        AS      = 1'b1;
        cnt_d   = 3'd0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        AS = 1'b1;
        DS = 2'b01;
        if (cnt_q == FW) begin
          IR_load = 1'b1;
          cnt_d   = 3'd0;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DECODE: begin
        rdAddrA = IR_out[9:5];
        rdAddrB = IR_out[20:16];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rdAddrA = IR_out[9:5];
        rdAddrB = IR_out[20:16];
        PS      = 2'b01;
        state_d = ST_FETCH;
        // Opcode widths are tested longest first so short prefixes never shadow R/D-type encodings.
        if (is_add || is_sub || is_and || is_orr) begin
          FS     = is_sub ? 5'b01001 : is_and ? 5'b00000 : is_orr ? 5'b00100 : 5'b01000;
          C_in   = is_sub;
          write  = 1'b1;
          wrAddr = IR_out[4:0];
        end else if (is_ldur) begin
          FS      = 5'b01000;
          B_sel   = 1'b1;
          K       = dt_sext;
          DS      = 2'b01;
          PS      = 2'b00;
          state_d = ST_MEM;
        end else if (is_stur) begin
          FS       = 5'b01000;
          B_sel    = 1'b1;
          K        = dt_sext;
          rdAddrB  = IR_out[4:0];
          ramWrite = 1'b1;
        end else if (is_addi) begin
          FS     = 5'b01000;
          B_sel  = 1'b1;
          K      = imm_zext;
          write  = 1'b1;
          wrAddr = IR_out[4:0];
        end else if (is_cbz) begin
          rdAddrA = IR_out[4:0];
          FS      = 5'b01100;
          K       = cb_sext;
          PS      = zero ? 2'b11 : 2'b01;
        end else if (is_b) begin
          K  = br_sext;
          PS = 2'b11;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          PS        = 2'b00;
          illegal_d = 1'b1;
          state_d   = ST_HALT;
`endif
        end
      end
      ST_MEM: begin
        // The ALU keeps forming the load address while RAM drives the bus into the register file.
        rdAddrA = IR_out[9:5];
        FS      = 5'b01000;
        B_sel   = 1'b1;
        K       = dt_sext;
        DS      = 2'b01;
        write   = 1'b1;
        wrAddr  = IR_out[4:0];
        PS      = 2'b01;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with FETCH_WAIT=1; honours ILLEGAL_TRAP_EN when defined.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] IR_out;
  logic        zero;
  logic        write;
  logic [4:0]  rdAddrA, rdAddrB, wrAddr;
  logic [63:0] K;
  logic [4:0]  FS;
  logic        C_in, B_sel, ramWrite, PC_sel;
  logic [1:0]  PS;
  logic        IR_load, AS;
  logic [1:0]  DS;
  logic [2:0]  state;
  logic        illegal;

  int vec_count = 0;
  int err_count = 0;

  control_unit #(.FETCH_WAIT(1)) dut (
    .clk(clk), .reset(reset), .IR_out(IR_out), .zero(zero),
    .write(write), .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .wrAddr(wrAddr),
    .K(K), .FS(FS), .C_in(C_in), .B_sel(B_sel), .ramWrite(ramWrite),
    .PC_sel(PC_sel), .PS(PS), .IR_load(IR_load), .AS(AS), .DS(DS),
    .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic z);
    IR_out = ir;
    zero   = z;
    #1;
  endtask

  // Walks FETCH (two cycles) and DECODE, leaving the bench sampling in EXEC.
  task automatic fetch_decode();
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(32'h0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    vec_count++;
    if (state !== 3'd0) begin err_count++; $display("[TB] FAIL reset_async_state: got %0d expected 0", state); end
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    vec_count++;
    if ({write, rdAddrA, rdAddrB, wrAddr, K, FS, C_in, B_sel, ramWrite, PC_sel, PS, IR_load, AS, DS, illegal} !== {93'd0, 1'b1, 3'd0}) begin
      err_count++; $display("[TB] FAIL reset_outputs: got AS=%b IR_load=%b DS=%b PS=%b K=%h", AS, IR_load, DS, PS, K);
    end
    reset = 1'b1;
    #1;
    vec_count++;
    if (state !== 3'd0) begin err_count++; $display("[TB] FAIL reset_release_state: got %0d expected 0", state); end
    step();
    vec_count++;
    if (state !== 3'd1 || IR_load !== 1'b0 || AS !== 1'b1 || DS !== 2'b01 || PS !== 2'b00) begin
      err_count++; $display("[TB] FAIL reset_first_fetch: got state=%0d IR_load=%b AS=%b DS=%b PS=%b", state, IR_load, AS, DS, PS);
    end
  endtask

  task automatic test_add();
    applyStimulus(32'h8B020023, 1'b0);
    step();
    vec_count++;
    if (state !== 3'd1 || IR_load !== 1'b1) begin err_count++; $display("[TB] FAIL add_ir_load: got state=%0d IR_load=%b expected 1/1", state, IR_load); end
    step();
    vec_count++;
    if (state !== 3'd2 || rdAddrA !== 5'd1 || rdAddrB !== 5'd2 || write !== 1'b0 || PS !== 2'b00) begin
      err_count++; $display("[TB] FAIL add_decode: got state=%0d rdA=%0d rdB=%0d write=%b PS=%b", state, rdAddrA, rdAddrB, write, PS);
    end
    step();
    vec_count++;
    if ({state, FS, C_in, B_sel, DS, rdAddrA, rdAddrB, wrAddr, write, PS, ramWrite} !== {3'd3, 5'b01000, 1'b0, 1'b0, 2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 2'b01, 1'b0}) begin
      err_count++; $display("[TB] FAIL add_exec: got state=%0d FS=%b C_in=%b rdA=%0d rdB=%0d wr=%0d write=%b PS=%b expected 3 01000 0 1 2 3 1 01", state, FS, C_in, rdAddrA, rdAddrB, wrAddr, write, PS);
    end
    step();
    vec_count++;
    if (state !== 3'd1 || write !== 1'b0) begin err_count++; $display("[TB] FAIL add_back_to_fetch: got state=%0d write=%b expected 1 0", state, write); end
  endtask

  task automatic test_sub_x31();
    applyStimulus({11'b11001011000, 5'd9, 6'd0, 5'd8, 5'd31}, 1'b0);
    fetch_decode();
    vec_count++;
    if ({FS, C_in, wrAddr, write, rdAddrA, rdAddrB} !== {5'b01001, 1'b1, 5'd31, 1'b1, 5'd8, 5'd9}) begin
      err_count++; $display("[TB] FAIL sub_exec: got FS=%b C_in=%b wr=%0d write=%b rdA=%0d rdB=%0d expected 01001 1 31 1 8 9", FS, C_in, wrAddr, write, rdAddrA, rdAddrB);
    end
    step();
  endtask

  task automatic test_logic_ops();
    applyStimulus({11'b10001010000, 5'd2, 6'd0, 5'd1, 5'd4}, 1'b0);
    fetch_decode();
    vec_count++;
    if (FS !== 5'b00000 || C_in !== 1'b0 || write !== 1'b1) begin err_count++; $display("[TB] FAIL and_exec: got FS=%b C_in=%b write=%b expected 00000 0 1", FS, C_in, write); end
    step();
    applyStimulus({11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd4}, 1'b0);
    fetch_decode();
    vec_count++;
    if (FS !== 5'b00100 || write !== 1'b1 || wrAddr !== 5'd4) begin err_count++; $display("[TB] FAIL orr_exec: got FS=%b write=%b wr=%0d expected 00100 1 4", FS, write, wrAddr); end
    step();
  endtask

  task automatic test_addi();
    applyStimulus({10'b1001000100, 12'hFFF, 5'd2, 5'd7}, 1'b0);
    fetch_decode();
    vec_count++;
    if ({K, B_sel, FS, write, wrAddr, rdAddrA, PS} !== {64'h0000_0000_0000_0FFF, 1'b1, 5'b01000, 1'b1, 5'd7, 5'd2, 2'b01}) begin
      err_count++; $display("[TB] FAIL addi_exec: got K=%h B_sel=%b FS=%b write=%b wr=%0d rdA=%0d PS=%b", K, B_sel, FS, write, wrAddr, rdAddrA, PS);
    end
    step();
  endtask

  task automatic test_ldur();
    applyStimulus(32'hF85F8025, 1'b0);
    fetch_decode();
    vec_count++;
    if ({state, K, AS, DS, PS, B_sel, FS, write, ramWrite} !== {3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 2'b01, 2'b00, 1'b1, 5'b01000, 1'b0, 1'b0}) begin
      err_count++; $display("[TB] FAIL ldur_exec: got state=%0d K=%h AS=%b DS=%b PS=%b B_sel=%b write=%b", state, K, AS, DS, PS, B_sel, write);
    end
    step();
    vec_count++;
    if ({state, write, wrAddr, PS, AS, DS, ramWrite} !== {3'd4, 1'b1, 5'd5, 2'b01, 1'b0, 2'b01, 1'b0}) begin
      err_count++; $display("[TB] FAIL ldur_mem: got state=%0d write=%b wr=%0d PS=%b AS=%b DS=%b expected 4 1 5 01 0 01", state, write, wrAddr, PS, AS, DS);
    end
    step();
    vec_count++;
    if (state !== 3'd1) begin err_count++; $display("[TB] FAIL ldur_back_to_fetch: got %0d expected 1", state); end
  endtask

  task automatic test_stur();
    applyStimulus({11'b11111000000, 9'd16, 2'b00, 5'd1, 5'd5}, 1'b0);
    fetch_decode();
    vec_count++;
    if ({ramWrite, write, rdAddrB, rdAddrA, K, PS, AS, B_sel} !== {1'b1, 1'b0, 5'd5, 5'd1, 64'd16, 2'b01, 1'b0, 1'b1}) begin
      err_count++; $display("[TB] FAIL stur_exec: got ramWrite=%b write=%b rdB=%0d rdA=%0d K=%h PS=%b AS=%b", ramWrite, write, rdAddrB, rdAddrA, K, PS, AS);
    end
    step();
    vec_count++;
    if (state !== 3'd1 || ramWrite !== 1'b0) begin err_count++; $display("[TB] FAIL stur_back_to_fetch: got state=%0d ramWrite=%b expected 1 0", state, ramWrite); end
  endtask

  task automatic test_cbz();
    applyStimulus(32'hB4000064, 1'b1);
    fetch_decode();
    vec_count++;
    if ({PS, K, rdAddrA, FS, write} !== {2'b11, 64'd3, 5'd4, 5'b01100, 1'b0}) begin
      err_count++; $display("[TB] FAIL cbz_taken: got PS=%b K=%h rdA=%0d FS=%b write=%b expected 11 3 4 01100 0", PS, K, rdAddrA, FS, write);
    end
    applyStimulus(32'hB4000064, 1'b0);
    vec_count++;
    if (PS !== 2'b01) begin err_count++; $display("[TB] FAIL cbz_not_taken: got PS=%b expected 01", PS); end
    step();
  endtask

  task automatic test_branch();
    applyStimulus(32'h17FFFFFF, 1'b0);
    fetch_decode();
    vec_count++;
    if (PS !== 2'b11 || K !== 64'hFFFF_FFFF_FFFF_FFFF || write !== 1'b0) begin
      err_count++; $display("[TB] FAIL b_exec: got PS=%b K=%h write=%b expected 11 all-ones 0", PS, K, write);
    end
    step();
    vec_count++;
    if (state !== 3'd1 || PS !== 2'b00) begin err_count++; $display("[TB] FAIL b_back_to_fetch: got state=%0d PS=%b expected 1 00", state, PS); end
  endtask

  task automatic test_illegal();
    applyStimulus(32'h0000_0000, 1'b0);
    fetch_decode();
`ifdef ILLEGAL_TRAP_EN
    vec_count++;
    if (PS !== 2'b00 || write !== 1'b0 || ramWrite !== 1'b0) begin err_count++; $display("[TB] FAIL illegal_exec: got PS=%b write=%b ramWrite=%b expected 00 0 0", PS, write, ramWrite); end
    for (int i = 0; i < 10; i++) begin
      step();
      vec_count++;
      if (state !== 3'd5 || illegal !== 1'b1 || PS !== 2'b00 || write !== 1'b0) begin
        err_count++; $display("[TB] FAIL illegal_halt_%0d: got state=%0d illegal=%b PS=%b write=%b expected 5 1 00 0", i, state, illegal, PS, write);
      end
    end
    reset = 1'b0;
    #1;
    vec_count++;
    if (state !== 3'd0 || illegal !== 1'b0) begin err_count++; $display("[TB] FAIL illegal_cleared: got state=%0d illegal=%b expected 0 0", state, illegal); end
    reset = 1'b1;
`else
    vec_count++;
    if (PS !== 2'b01 || write !== 1'b0 || illegal !== 1'b0) begin err_count++; $display("[TB] FAIL illegal_nop: got PS=%b write=%b illegal=%b expected 01 0 0", PS, write, illegal); end
    step();
    vec_count++;
    if (state !== 3'd1 || illegal !== 1'b0) begin err_count++; $display("[TB] FAIL illegal_back_to_fetch: got state=%0d illegal=%b expected 1 0", state, illegal); end
`endif
  endtask

  initial begin
    reset  = 1'b0;
    IR_out = 32'h0;
    zero   = 1'b0;
    test_reset();
    test_add();
    test_sub_x31();
    test_logic_ops();
    test_addi();
    test_ldur();
    test_stur();
    test_cbz();
    test_branch();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
